// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins arbitration; a bounded data streak keeps fetch moving.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_READ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_RDATA,
    output logic        I_BUSYWAIT,
    input  logic        D_READ,
    input  logic        D_WRITE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic [31:0] D_RDATA,
    output logic        D_BUSYWAIT,
    output logic        M_READ,
    output logic        M_WRITE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic [31:0] M_RDATA,
    input  logic        M_BUSYWAIT
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t        r_state;
    state_t        w_pick;
    logic [SW-1:0] r_streak;
    logic [SW-1:0] w_streak_nxt;
    logic          w_d_req;
    logic          w_strobe;
    logic          w_i_done;
    logic          w_d_done;
    logic          w_rearb;

    assign w_d_req = D_READ | D_WRITE;

    always_comb begin
        M_READ  = 1'b0;
        M_WRITE = 1'b0;
        M_ADDR  = '0;
        M_WDATA = '0;
        I_RDATA = '0;
        D_RDATA = '0;
        unique case (r_state)
            SERVE_D: begin
                M_WRITE = D_WRITE;
                M_READ  = D_READ & ~D_WRITE;
                M_ADDR  = D_ADDR;
                M_WDATA = D_WDATA;
                D_RDATA = M_RDATA;
            end
            SERVE_I: begin
                M_READ  = I_READ;
                M_ADDR  = I_ADDR;
                I_RDATA = M_RDATA;
            end
            default: ;
        endcase
    end

    assign I_BUSYWAIT = I_READ & ~((r_state == SERVE_I) & ~M_BUSYWAIT);
    assign D_BUSYWAIT = w_d_req & ~((r_state == SERVE_D) & ~M_BUSYWAIT);

    assign w_strobe = M_READ | M_WRITE;
    assign w_i_done = (r_state == SERVE_I) & w_strobe & ~M_BUSYWAIT;
    assign w_d_done = (r_state == SERVE_D) & w_strobe & ~M_BUSYWAIT;
    // A serve state with its strobe dropped also re-arbitrates.
    assign w_rearb  = (r_state == IDLE) | ~w_strobe | ~M_BUSYWAIT;

    always_comb begin
        w_streak_nxt = r_streak;
        if (!I_READ || w_i_done) begin
            w_streak_nxt = '0;
        end else if (w_d_done && r_streak != MAX_S) begin
            w_streak_nxt = r_streak + SW'(1);
        end
    end

    always_comb begin
        w_pick = IDLE;
        if (w_d_req && !(I_READ && w_streak_nxt == MAX_S)) begin
            w_pick = SERVE_D;
        end else if (I_READ) begin
            w_pick = SERVE_I;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            r_streak <= w_streak_nxt;
            if (w_rearb) begin
                r_state <= w_pick;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner
// sequences and randomized traffic against a reference model.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        I_READ = 1'b0;
    logic [31:0] I_ADDR = '0;
    logic [31:0] I_RDATA;
    logic        I_BUSYWAIT;
    logic        D_READ = 1'b0;
    logic        D_WRITE = 1'b0;
    logic [31:0] D_ADDR = '0;
    logic [31:0] D_WDATA = '0;
    logic [31:0] D_RDATA;
    logic        D_BUSYWAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [31:0] M_RDATA = '0;
    logic        M_BUSYWAIT = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.MAX_D_STREAK(MAX)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .I_READ(I_READ),
        .I_ADDR(I_ADDR),
        .I_RDATA(I_RDATA),
        .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ),
        .D_WRITE(D_WRITE),
        .D_ADDR(D_ADDR),
        .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA),
        .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ),
        .M_WRITE(M_WRITE),
        .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA),
        .M_RDATA(M_RDATA),
        .M_BUSYWAIT(M_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        mb;
        logic [31:0] mrd;
        logic [131:0] exp;
    } vec_t;

    // {mr, mw, ma, mwd, ird, drd, ib, db}
    function automatic logic [131:0] ex(
        input logic mr, input logic mw,
        input logic [31:0] ma, input logic [31:0] mwd,
        input logic [31:0] ird, input logic [31:0] drd,
        input logic ib, input logic db);
        return {mr, mw, ma, mwd, ird, drd, ib, db};
    endfunction

    function automatic vec_t mkv(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd,
        input logic mb, input logic [31:0] mrd,
        input logic [131:0] e);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
        v.da = da; v.dwd = dwd; v.mb = mb; v.mrd = mrd;
        v.exp = e;
        return v;
    endfunction

    function automatic logic [131:0] dut_out();
        return {M_READ, M_WRITE, M_ADDR, M_WDATA,
                I_RDATA, D_RDATA, I_BUSYWAIT, D_BUSYWAIT};
    endfunction

    task automatic cmp(input string nm, input logic [131:0] got,
                       input logic [131:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic zero_inputs();
        I_READ = 0; I_ADDR = 0; D_READ = 0; D_WRITE = 0;
        D_ADDR = 0; D_WDATA = 0; M_RDATA = 0; M_BUSYWAIT = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        zero_inputs();
        @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    // Reference: which port owns the memory (0 none, 1 fetch, 2 data)
    // and how many data accesses completed while fetch waited.
    function automatic logic [131:0] model_out(input int g);
        logic mr = 0;
        logic mw = 0;
        logic [31:0] ma = 0;
        logic [31:0] mwd = 0;
        logic [31:0] ird = 0;
        logic [31:0] drd = 0;
        logic ib;
        logic db;
        if (g == 2) begin
            mw = D_WRITE;
            mr = D_READ && !D_WRITE;
            ma = D_ADDR;
            mwd = D_WDATA;
            drd = M_RDATA;
        end else if (g == 1) begin
            mr = I_READ;
            ma = I_ADDR;
            ird = M_RDATA;
        end
        ib = I_READ && !(g == 1 && !M_BUSYWAIT);
        db = (D_READ || D_WRITE) && !(g == 2 && !M_BUSYWAIT);
        return {mr, mw, ma, mwd, ird, drd, ib, db};
    endfunction

    task automatic model_step(inout int g, inout int s);
        bit want_d;
        bit active;
        bit done;
        int ns;
        want_d = D_READ || D_WRITE;
        active = (g == 2 && want_d) || (g == 1 && I_READ);
        done = active && !M_BUSYWAIT;
        if (!I_READ) ns = 0;
        else if (done && g == 1) ns = 0;
        else if (done && g == 2) ns = (s + 1 > MAX) ? MAX : s + 1;
        else ns = s;
        if (g == 0 || !active || done) begin
            if (want_d && !(I_READ && ns >= MAX)) g = 2;
            else if (I_READ) g = 1;
            else g = 0;
        end
        s = ns;
    endtask

    vec_t tbl[10];

    initial begin
        string ev;
        int busy;
        bit stable;
        int g;
        int s;
        bit i_hold;
        bit d_hold;

        tbl[0] = mkv(1, 32'h40, 0, 0, 0, 0, 0, 32'h11111111,
                     ex(0, 0, 0, 0, 0, 0, 1, 0));
        tbl[1] = mkv(1, 32'h40, 0, 0, 0, 0, 0, 32'h11111111,
                     ex(1, 0, 32'h40, 0, 32'h11111111, 0, 0, 0));
        tbl[2] = mkv(0, 0, 0, 0, 0, 0, 0, 0,
                     ex(0, 0, 0, 0, 0, 0, 0, 0));
        tbl[3] = mkv(1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h22,
                     ex(0, 0, 0, 0, 0, 0, 1, 1));
        tbl[4] = mkv(1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h22,
                     ex(0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h22, 1, 0));
        tbl[5] = mkv(1, 32'h44, 0, 0, 0, 0, 0, 0,
                     ex(0, 0, 0, 0, 0, 0, 1, 0));
        tbl[6] = mkv(1, 32'h44, 0, 0, 0, 0, 0, 32'h33,
                     ex(1, 0, 32'h44, 0, 32'h33, 0, 0, 0));
        tbl[7] = mkv(0, 0, 1, 1, 32'h200, 32'h5, 0, 0,
                     ex(0, 0, 0, 0, 0, 0, 0, 1));
        tbl[8] = mkv(0, 0, 1, 1, 32'h200, 32'h5, 0, 0,
                     ex(0, 1, 32'h200, 32'h5, 0, 0, 0, 0));
        tbl[9] = mkv(0, 0, 0, 0, 0, 0, 0, 0,
                     ex(0, 0, 0, 0, 0, 0, 0, 0));

        // reset state: strobes and data low, busywaits follow requests
        #1 RESET = 1'b1;
        I_READ = 1; D_WRITE = 1; M_RDATA = 32'hA5A5A5A5;
        #1 cmp("reset_state", dut_out(), ex(0, 0, 0, 0, 0, 0, 1, 1));

        do_reset();
        foreach (tbl[i]) begin
            @(posedge CLK);
            #1;
            I_READ = tbl[i].ir; I_ADDR = tbl[i].ia;
            D_READ = tbl[i].dr; D_WRITE = tbl[i].dw;
            D_ADDR = tbl[i].da; D_WDATA = tbl[i].dwd;
            M_BUSYWAIT = tbl[i].mb; M_RDATA = tbl[i].mrd;
            #3 cmp($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // data streak limit forces one fetch through
        do_reset();
        @(posedge CLK);
        #1;
        D_READ = 1; I_READ = 1; D_ADDR = 32'h80; I_ADDR = 32'h10;
        ev = "";
        for (int c = 0; c < 7; c++) begin
            #3;
            if (!D_BUSYWAIT && M_READ && M_ADDR == 32'h80) ev = {ev, "D"};
            if (!I_BUSYWAIT && M_READ && M_ADDR == 32'h10) ev = {ev, "I"};
            @(posedge CLK);
            #1;
        end
        n_vec++;
        if (ev != "DDDDID") begin
            n_err++;
            $display("FAIL streak: got %s expected DDDDID", ev);
        end

        // memory wait states on a data read
        do_reset();
        @(posedge CLK);
        #1;
        D_READ = 1; D_ADDR = 32'h300; M_BUSYWAIT = 1;
        busy = 0;
        stable = 1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) M_BUSYWAIT = 0;
            #3;
            if (D_BUSYWAIT) busy++;
            if (c > 0 && !(M_READ && M_ADDR == 32'h300)) stable = 0;
            if (c == 4) cmp("wait_done", {131'b0, D_BUSYWAIT}, 132'b0);
            @(posedge CLK);
            #1;
        end
        cmp("wait_busy_cycles", 132'(busy), 132'd4);
        cmp("wait_addr_stable", {131'b0, stable}, 132'b1);

        // reset in the middle of a stalled data access
        do_reset();
        @(posedge CLK);
        #1;
        D_READ = 1; D_ADDR = 32'h500; M_BUSYWAIT = 1;
        @(posedge CLK);
        #3 cmp("rst_pre_grant", {131'b0, M_READ}, 132'b1);
        #1 RESET = 1'b1;
        #1 cmp("rst_strobes", {130'b0, M_READ, M_WRITE}, 132'b0);
        @(negedge CLK);
        RESET = 1'b0;
        M_BUSYWAIT = 0;
        #1 cmp("rst_idle", {130'b0, M_READ, D_BUSYWAIT}, 132'b01);
        @(posedge CLK);
        #3 cmp("rst_regrant",
               {M_ADDR, M_READ, D_BUSYWAIT}, {100'b0, 32'h500, 2'b10});

        // randomized traffic against the reference model
        do_reset();
        g = 0;
        s = 0;
        i_hold = 0;
        d_hold = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge CLK);
            #1;
            if (!i_hold || $urandom_range(0, 15) == 0) begin
                I_READ = ($urandom_range(0, 2) != 0);
                I_ADDR = $urandom;
            end
            if (!d_hold || $urandom_range(0, 15) == 0) begin
                int op;
                op = $urandom_range(0, 3);
                D_READ = op[0];
                D_WRITE = op[1];
                D_ADDR = $urandom;
                D_WDATA = $urandom;
            end
            M_BUSYWAIT = ($urandom_range(0, 3) == 0);
            M_RDATA = $urandom;
            #3 cmp($sformatf("rand[%0d]", c), dut_out(), model_out(g));
            i_hold = I_READ && !(g == 1 && !M_BUSYWAIT);
            d_hold = (D_READ || D_WRITE) && !(g == 2 && !M_BUSYWAIT);
            model_step(g, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
